// File: rtl/phase_timer_pkg.sv
// Shared definitions for the phase timer bank.
//   state_e  : per-channel timer state (IDLE / RUN / DONE), 2-bit encoding
//   PT_WIDTH : default count width in ticks
package phase_timer_pkg;

   localparam int PT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/phase_timer_ch.sv
// One down-count timer channel.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   tick_en                shared one-second strobe
//   start, abort, pause    channel controls (pulse, pulse, level)
//   auto_reload            mode captured with start (1 = periodic)
//   load_value             period captured with start
//   busy                   channel in RUN
//   expired                sticky done flag
//   expired_pulse          one-cycle strobe on each expiry
//   time_left              current count
module phase_timer_ch
   import phase_timer_pkg::*;
#(
   parameter int WIDTH = PT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_en,
   input  logic             start,
   input  logic             abort,
   input  logic             pause,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_value,
   output logic             busy,
   output logic             expired,
   output logic             expired_pulse,
   output logic [WIDTH-1:0] time_left
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic             expired_q, expired_d;
   logic             pulse_q, pulse_d;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      mode_d    = mode_q;
      expired_d = expired_q;
      pulse_d   = 1'b0;
      if (abort) begin
         state_d   = ST_IDLE;
         count_d   = '0;
         expired_d = 1'b0;
      end else if (start) begin
         // A restart swallows any expiry that would have happened this cycle.
         state_d   = ST_RUN;
         count_d   = load_value;
         reload_d  = load_value;
         mode_d    = auto_reload;
         expired_d = 1'b0;
      end else if (state_q == ST_RUN) begin
         if (count_q == '0) begin
            // Zero period: expire once without waiting for a tick, and never
            // reload, so a periodic zero-length timer cannot oscillate.
            state_d   = ST_DONE;
            expired_d = 1'b1;
            pulse_d   = 1'b1;
         end else if (tick_en && !pause) begin
            if (count_q == WIDTH'(1)) begin
               expired_d = 1'b1;
               pulse_d   = 1'b1;
               if (mode_q) begin
                  count_d = reload_q;
               end else begin
                  count_d = '0;
                  state_d = ST_DONE;
               end
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         mode_q    <= 1'b0;
         expired_q <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         mode_q    <= mode_d;
         expired_q <= expired_d;
         pulse_q   <= pulse_d;
      end
   end

   assign busy          = (state_q == ST_RUN);
   assign expired       = expired_q;
   assign expired_pulse = pulse_q;
   assign time_left     = count_q;

endmodule

// File: rtl/phase_timer_bank.sv
// Bank of NUM_CH independent phase timers sharing one tick strobe.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   tick_en         shared one-second strobe
//   start/abort     per-channel pulses
//   pause           per-channel hold level
//   auto_reload     per-channel mode, sampled with start
//   load_value      per-channel period, ch i = [i*WIDTH +: WIDTH]
//   busy, expired, expired_pulse, time_left   per-channel status
//   any_expired     OR of expired
module phase_timer_bank
   import phase_timer_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = PT_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick_en,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       abort,
   input  logic [NUM_CH-1:0]       pause,
   input  logic [NUM_CH-1:0]       auto_reload,
   input  logic [NUM_CH*WIDTH-1:0] load_value,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       expired,
   output logic [NUM_CH-1:0]       expired_pulse,
   output logic [NUM_CH*WIDTH-1:0] time_left,
   output logic                    any_expired
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      phase_timer_ch #(.WIDTH(WIDTH)) u_ch (
         .clk           (clk),
         .reset         (reset),
         .tick_en       (tick_en),
         .start         (start[i]),
         .abort         (abort[i]),
         .pause         (pause[i]),
         .auto_reload   (auto_reload[i]),
         .load_value    (load_value[i*WIDTH +: WIDTH]),
         .busy          (busy[i]),
         .expired       (expired[i]),
         .expired_pulse (expired_pulse[i]),
         .time_left     (time_left[i*WIDTH +: WIDTH])
      );
   end

   assign any_expired = |expired;

endmodule
